// File: rtl/main_fsm_if.sv
// main_fsm_if: instruction fields, ALU flags and memory strobe in; datapath enables and selects out.
interface main_fsm_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       MemReady;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] ALUControl;
  modport master (
    output Cond, Op, Funct, Rd, ALUFlags, MemReady,
    input  PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );
  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags, MemReady,
    output PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
  );
endinterface

// File: rtl/main_fsm.sv
// main_fsm: multicycle ARM-subset control FSM with conditional execution and NZCV flags.
// Define MAIN_FSM_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR until MemReady.
module main_fsm (
  input logic       clk,
  input logic       reset,
  main_fsm_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9, UNKNOWN = 4'd10
  } state_t;
  state_t     r_state;
  logic [3:0] r_flags;
  logic       r_condex;
  logic [3:0] w_cmd;
  logic       w_cmp;
  logic       w_cv;
  logic       w_mr;
  logic       w_base;
  logic       w_condex;
  logic       w_fd;
  logic       w_regwrite;
  logic [1:0] w_aluc;
  assign w_cmd = bus.Funct[4:1];
  assign w_cmp = w_cmd == 4'b1010;
  assign w_cv  = w_cmd == 4'b0100 || w_cmd == 4'b0010 || w_cmp;
`ifdef MAIN_FSM_MEM_WAIT_EN
  assign w_mr = bus.MemReady;
`else
  assign w_mr = bus.MemReady | 1'b1;
`endif
  // Odd condition codes are the inverse of the even code below them, including AL/1111.
  always_comb begin
    w_base = 1'b1;
    case (bus.Cond[3:1])
      3'd0: w_base = r_flags[2];
      3'd1: w_base = r_flags[1];
      3'd2: w_base = r_flags[3];
      3'd3: w_base = r_flags[0];
      3'd4: w_base = r_flags[1] & ~r_flags[2];
      3'd5: w_base = r_flags[3] == r_flags[0];
      3'd6: w_base = ~r_flags[2] & (r_flags[3] == r_flags[0]);
      default: w_base = 1'b1;
    endcase
  end
  assign w_condex = w_base ^ bus.Cond[0];
  assign w_aluc = w_cmd == 4'b0100 ? 2'b00 :
                  w_cmd == 4'b0010 || w_cmp ? 2'b01 :
                  w_cmd == 4'b0000 ? 2'b10 :
                  w_cmd == 4'b1100 ? 2'b11 : 2'b00;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= FETCH;
      r_flags  <= 4'b0000;
      r_condex <= 1'b0;
    end else begin
      case (r_state)
        FETCH:  if (w_mr) r_state <= DECODE;
        DECODE: begin
          r_condex <= w_condex;
          r_state  <= bus.Op == 2'b01 ? MEMADR :
                      bus.Op == 2'b10 ? BRANCH :
                      bus.Op == 2'b11 ? UNKNOWN :
                      bus.Funct[5] ? EXECUTEI : EXECUTER;
        end
        MEMADR: r_state <= bus.Funct[0] ? MEMRD : MEMWR;
        MEMRD:  if (w_mr) r_state <= MEMWB;
        MEMWR:  if (w_mr) r_state <= FETCH;
        EXECUTER, EXECUTEI: begin
          r_state <= ALUWB;
          if (r_condex && bus.Funct[0]) begin
            r_flags[3:2] <= bus.ALUFlags[3:2];
            if (w_cv) r_flags[1:0] <= bus.ALUFlags[1:0];
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end
  assign w_fd       = r_state == FETCH || r_state == DECODE;
  assign w_regwrite = r_condex && ((r_state == ALUWB && !w_cmp) || r_state == MEMWB);
  // Enables are gated by reset so they drop immediately, without waiting for a clock.
  assign bus.PCWrite  = reset && ((r_state == FETCH && w_mr) || (r_state == BRANCH && r_condex) ||
                                  (w_regwrite && bus.Rd == 4'd15));
  assign bus.RegWrite = reset && w_regwrite;
  assign bus.MemWrite = reset && r_state == MEMWR && r_condex;
  assign bus.IRWrite  = reset && r_state == FETCH && w_mr;
  assign bus.AdrSrc   = r_state == MEMRD || r_state == MEMWR;
  assign bus.ALUSrcA  = w_fd ? 2'b01 : 2'b00;
  assign bus.ALUSrcB  = w_fd ? 2'b10 :
                        (r_state == MEMADR || r_state == EXECUTEI || r_state == BRANCH) ? 2'b01 : 2'b00;
  assign bus.ResultSrc = (w_fd || r_state == BRANCH) ? 2'b10 : r_state == MEMWB ? 2'b01 : 2'b00;
  assign bus.ALUControl = (r_state == EXECUTER || r_state == EXECUTEI) ? w_aluc : 2'b00;
  assign bus.ImmSrc  = bus.Op;
  assign bus.RegSrc  = {bus.Op == 2'b01 && !bus.Funct[0], bus.Op == 2'b10};
endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: randomized instruction stream checked cycle by cycle against an instruction-level model.
module tb_main_fsm;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  main_fsm_if bus();
  main_fsm dut (.clk(clk), .reset(reset), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] m_flags = 4'b0000;
  logic [1:0] alu_of [16];
  logic [1:0] t_op;
  logic [5:0] t_fn;
  logic [3:0] t_rd;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return cy;
      4'd3: return !cy;
      4'd4: return n;
      4'd5: return !n;
      4'd6: return v;
      4'd7: return !v;
      4'd8: return cy && !z;
      4'd9: return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && n == v;
      4'd13: return z || n != v;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  function automatic logic [20:0] exp_out(input int st, input bit ce, input bit mr);
    bit pcw = 0, rw = 0, mw = 0, irw = 0, adr = 0, rdy;
    logic [1:0] asa = 0, asb = 0, res = 0, aluc = 0;
`ifdef MAIN_FSM_MEM_WAIT_EN
    rdy = mr;
`else
    rdy = 1'b1 | mr;
`endif
    case (st)
      0: begin irw = rdy; pcw = rdy; asa = 2'd1; asb = 2'd2; res = 2'd2; end
      1: begin asa = 2'd1; asb = 2'd2; res = 2'd2; end
      2: asb = 2'd1;
      3: adr = 1'b1;
      4: begin res = 2'd1; rw = ce; end
      5: begin adr = 1'b1; mw = ce; end
      6, 7: begin asb = st == 7 ? 2'd1 : 2'd0; aluc = alu_of[t_fn[4:1]]; end
      8: rw = ce && t_fn[4:1] != 4'b1010;
      9: begin asb = 2'd1; res = 2'd2; pcw = ce; end
      default: ;
    endcase
    if ((st == 4 || st == 8) && rw && t_rd == 4'd15) pcw = 1'b1;
    return {4'(st), pcw, rw, mw, irw, adr, t_op == 2'b01 && !t_fn[0], t_op == 2'b10, asa, asb, res, t_op, aluc};
  endfunction
  function automatic logic [20:0] obs();
    return {4'(dut.r_state), bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.IRWrite, bus.AdrSrc,
            bus.RegSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.ALUControl};
  endfunction
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] af);
    int seq[$];
    bit ce;
    ce = cond_ok(c, m_flags);
    seq = {0, 1};
    case (o)
      2'b00: begin seq.push_back(f[5] ? 7 : 6); seq.push_back(8); end
      2'b01: if (f[0]) begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
             else begin seq.push_back(2); seq.push_back(5); end
      2'b10: seq.push_back(9);
      default: seq.push_back(10);
    endcase
    t_op = o; t_fn = f; t_rd = r;
    bus.Cond = c; bus.Op = o; bus.Funct = f; bus.Rd = r; bus.ALUFlags = af;
    foreach (seq[i]) begin
      int w = 0;
`ifdef MAIN_FSM_MEM_WAIT_EN
      if (seq[i] == 0 || seq[i] == 3 || seq[i] == 5) w = $urandom_range(0, 3);
`endif
      for (int k = 0; k <= w; k++) begin
`ifdef MAIN_FSM_MEM_WAIT_EN
        bus.MemReady = k == w;
`else
        bus.MemReady = 1'($urandom_range(0, 1));
`endif
        #1;
        check($sformatf("st%0d_c%h_o%0d_f%b", seq[i], c, o, f), 32'(obs()), 32'(exp_out(seq[i], ce, bus.MemReady)));
        @(negedge clk);
      end
    end
    if (o == 2'b00 && ce && f[0]) begin
      m_flags[3:2] = af[3:2];
      if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010 || f[4:1] == 4'b1010) m_flags[1:0] = af[1:0];
    end
    check("flags", 32'(dut.r_flags), 32'(m_flags));
  endtask
  initial begin
    foreach (alu_of[i]) alu_of[i] = 2'b00;
    alu_of[4'b0010] = 2'b01;
    alu_of[4'b0000] = 2'b10;
    alu_of[4'b1100] = 2'b11;
    alu_of[4'b1010] = 2'b01;
    bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.ALUFlags = 4'd0; bus.MemReady = 1'b1;
    #1;
    check("rst_state", 32'(dut.r_state), 32'd0);
    check("rst_en", 32'({bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.IRWrite}), 32'd0);
    check("rst_flags_condex", 32'({dut.r_flags, dut.r_condex}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_instr(4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000);
    run_instr(4'hE, 2'b00, 6'b000101, 4'd2, 4'b0100);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000);
    run_instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000);
    run_instr(4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000);
    run_instr(4'h1, 2'b01, 6'b011000, 4'd3, 4'b0000);
    run_instr(4'hE, 2'b00, 6'b010101, 4'd4, 4'b1001);
    run_instr(4'hE, 2'b11, 6'b111111, 4'd15, 4'b1111);
    run_instr(4'hF, 2'b00, 6'b001001, 4'd15, 4'b1111);
    // Abandon an LDR in MEMRD with an asynchronous reset.
    bus.Cond = 4'hE; bus.Op = 2'b01; bus.Funct = 6'b011001; bus.Rd = 4'd15; bus.MemReady = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_memrd", 32'(dut.r_state), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("async_rst_state", 32'(dut.r_state), 32'd0);
    check("async_rst_en", 32'({bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.IRWrite}), 32'd0);
    @(negedge clk);
    check("rst_hold_flags", 32'({dut.r_flags, dut.r_condex, 4'(dut.r_state)}), 32'd0);
    reset = 1'b1;
    #1;
    check("rel_irwrite", 32'({bus.IRWrite, 4'(dut.r_state)}), 32'h10);
    m_flags = 4'b0000;
    run_instr(4'hE, 2'b00, 6'b101001, 4'd5, 4'b0110);
    for (int n = 0; n < 300; n++)
      run_instr(4'($urandom), 2'($urandom), 6'($urandom), 4'($urandom), 4'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
